// File: rtl/stream_mux_pkg.sv
// Shared constants for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

    localparam logic IDLE   = 1'b0;
    localparam logic LOCKED = 1'b1;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE   = IDLE,
        ST_LOCKED = LOCKED
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or above ptr wins,
// wrapping from N_CH-1 back to 0.
module rr_arbiter #(
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] gnt_idx
);

    int               idx;
    logic [SEL_W-1:0] ix;

    // Scan offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        ix        = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            ix = SEL_W'(idx);
            if (req[ix]) begin
                gnt_valid = 1'b1;
                gnt_idx   = ix;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream multiplexer with registered output, packet locking and
// fixed-select or round-robin arbitration.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 16,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] ptr_q;

    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;

    logic             grant_valid;
    logic [SEL_W-1:0] grant_ch;
    logic             slot_free;
    logic             xfer;
    logic [DATA_W-1:0] grant_data;
    logic             grant_last;

    rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        if (state_q == ST_LOCKED) begin
            grant_ch    = lock_ch_q;
            grant_valid = in_valid[lock_ch_q];
        end else if (mode == MODE_FIXED) begin
            grant_ch    = sel;
            grant_valid = (32'(sel) < N_CH) && in_valid[sel];
        end else begin
            grant_ch    = rr_idx;
            grant_valid = rr_valid;
        end
    end

    assign slot_free  = !out_valid || out_ready;
    assign xfer       = grant_valid && slot_free && !rst;
    assign grant_data = in_data[int'(grant_ch)*DATA_W +: DATA_W];
    assign grant_last = in_last[grant_ch];

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign in_ready[i] = xfer && (grant_ch == SEL_W'(i));
    end

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && !grant_last) begin
                    state_d   = ST_LOCKED;
                    lock_ch_d = grant_ch;
                end
            end
            ST_LOCKED: begin
                if (xfer && grant_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lock_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
        end
    end

    // Fairness pointer advances past whichever channel just closed a packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer && grant_last) begin
            if (grant_ch == SEL_W'(N_CH - 1)) ptr_q <= '0;
            else                               ptr_q <= grant_ch + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_ch    <= grant_ch;
            out_last  <= grant_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
